banco_reg_entrada_param: RTL and testbench
==========================================

Name: banco_reg_entrada_param

Overview:
Parametrised input register bank between the RTC/keyboard datapath and the PicoBlaze INPUT port. It holds N_DATA data registers loaded from the shared `entrada` bus, plus a keyboard byte register. Three event inputs are edge-detected into sticky status flags that clear on read, and the bank drives the processor interrupt request. A registered, address-decoded read mux replaces the external multiplexer.

Parameters:
DATA_W, 8, width of every data/keyboard register and of in_port
N_DATA, 11, number of general data registers loaded from entrada (1..64)
ADDR_W, 8, width of port_id
BASE_ADDR, 8'h00, port address of the status register; key register at BASE_ADDR+1; data register i at BASE_ADDR+2+i

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
entrada  in  DATA_W  shared data bus for data registers
wr_en  in  N_DATA  per-register load enable; bit i loads entrada into data reg i
irq  in  1  RTC interrupt event (level, edge-detected)
ready  in  1  RTC transfer-complete event (level, edge-detected)
new_data  in  1  keyboard byte-valid event (level, edge-detected)
data_teclado  in  DATA_W  keyboard byte, captured on new_data rising edge
port_id  in  ADDR_W  PicoBlaze port address
read_strobe  in  1  PicoBlaze read strobe, one cycle per INPUT
in_port  out  DATA_W  registered read data
interrupt  out  1  interrupt request to PicoBlaze
interrupt_ack  in  1  PicoBlaze interrupt acknowledge

Behaviour:
- Reset:
  - Asynchronous on reset=0. All data regs, key reg, status flags, in_port and interrupt go to 0.
  - The edge-detect history registers go to 1, so an input held high through reset produces no event.
- Edge detect:
  - rise_x = x & ~x_d, where x_d is x registered each cycle.
  - Event inputs are assumed synchronous to clk.
- Data regs:
  - On a clock with wr_en[i]=1, data_reg[i] <= entrada. Otherwise hold.
  - Several enables high in one cycle load the same value into all selected registers.
- Key reg:
  - On rise_new_data, key_reg <= data_teclado.
- Status register layout: bit0 irq_f, bit1 ready_f, bit2 new_f, bit3 ovf_f; remaining bits read 0.
- Flag set rules:
  - rise_irq sets irq_f.
  - rise_ready sets ready_f.
  - rise_new_data sets new_f. If new_f is already 1 and is not being cleared in the same cycle, ovf_f is also set; key_reg is still overwritten (newest byte wins).
- Read mux and latency:
  - Read address = port_id - BASE_ADDR.
  - in_port is updated every clock with the mux value selected by port_id, independent of read_strobe. Latency is 1 clock from port_id.
  - Unmapped addresses return 0.
- Clear-on-read, applied on the read_strobe cycle:
  - Status address: clears irq_f and ready_f.
  - Key address: clears new_f and ovf_f.
  - Data regs have no read side effects.
  - Clears use the flag values the CPU is reading. A set arriving in the same cycle as its clear wins: the flag stays 1 and the new event is not lost.
- Interrupt:
  - Set on rise_irq; cleared when interrupt_ack=1.
  - A simultaneous rise_irq and interrupt_ack leaves interrupt=1.
  - Independent of irq_f, which is cleared only by a status read.
- Reset mid-operation: reset wins over everything asynchronously; pending events are discarded.
- Width rules:
  - Address compare uses full ADDR_W width with wrap-around subtraction. Addresses below BASE_ADDR wrap to large values and read 0.
  - Elaboration must reject BASE_ADDR+N_DATA+1 > 2^ADDR_W-1.

Test Plan:
- Reset with irq=ready=new_data=1 held, release reset, hold inputs high 5 cycles -> status reads 8'h00, interrupt=0, all data regs and key reg read 0.
- wr_en=1<<3, entrada=8'h5A for one cycle, then port_id=BASE+5 -> in_port=8'h5A one clock later; all other data regs still 0; no flag change.
- Pulse new_data with data_teclado=8'h31, then again with 8'h32 before any read -> status reads 8'h0C, key reads 8'h32. A key read with read_strobe clears both bits, so status reads 8'h00.
- Pulse irq -> interrupt=1 and status bit0=1. interrupt_ack clears interrupt only (status still 8'h01). A status read clears bit0.
- Status read with read_strobe in the same cycle as a ready rising edge -> ready_f remains 1; the next status read returns 8'h02.
- port_id=BASE+2+N_DATA (unmapped) and port_id=BASE-1 -> in_port=8'h00; read_strobe on these addresses changes no flag.

Source files
------------

// File: rtl/banco_reg_entrada_param.sv
// Input register bank for the PicoBlaze INPUT port: data/keyboard registers,
// sticky clear-on-read event flags, interrupt request and a registered read mux.
module banco_reg_entrada_param #(
    parameter int                DATA_W    = 8,
    parameter int                N_DATA    = 11,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] entrada,
    input  logic [N_DATA-1:0] wr_en,
    input  logic              irq,
    input  logic              ready,
    input  logic              new_data,
    input  logic [DATA_W-1:0] data_teclado,
    input  logic [ADDR_W-1:0] port_id,
    input  logic              read_strobe,
    output logic [DATA_W-1:0] in_port,
    output logic              interrupt,
    input  logic              interrupt_ack
);

    // Reject configurations whose register map does not fit the port space.
    generate
        if (N_DATA < 1 || N_DATA > 64) begin : g_bad_n_data
            $error("banco_reg_entrada_param: N_DATA must be in 1..64");
        end
        if (DATA_W < 4) begin : g_bad_data_w
            $error("banco_reg_entrada_param: DATA_W must hold the 4 status bits");
        end
        if ((longint'(BASE_ADDR) + longint'(N_DATA) + 64'sd1) >
            ((64'sd1 <<< ADDR_W) - 64'sd1)) begin : g_bad_map
            $error("banco_reg_entrada_param: register map exceeds port_id range");
        end
    endgenerate

    logic              irq_hist_q, ready_hist_q, new_hist_q;
    logic              rise_irq, rise_ready, rise_new;
    logic [ADDR_W-1:0] rd_off;
    logic              clr_stat, clr_key;

    logic [DATA_W-1:0] data_q [N_DATA];
    logic [DATA_W-1:0] data_d [N_DATA];
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] in_port_q, rd_mux;
    logic              irq_f_q, irq_f_d;
    logic              ready_f_q, ready_f_d;
    logic              new_f_q, new_f_d;
    logic              ovf_f_q, ovf_f_d;
    logic              int_q, int_d;

    assign rise_irq   = irq      & ~irq_hist_q;
    assign rise_ready = ready    & ~ready_hist_q;
    assign rise_new   = new_data & ~new_hist_q;

    assign rd_off   = port_id - BASE_ADDR;
    assign clr_stat = read_strobe && (rd_off == ADDR_W'(0));
    assign clr_key  = read_strobe && (rd_off == ADDR_W'(1));

    always_comb begin
        for (int i = 0; i < N_DATA; i++) begin
            data_d[i] = wr_en[i] ? entrada : data_q[i];
        end
        key_d = rise_new ? data_teclado : key_q;
    end

    // A set arriving together with its clear wins, so no event is lost.
    always_comb begin
        irq_f_d   = rise_irq   | (irq_f_q   & ~clr_stat);
        ready_f_d = rise_ready | (ready_f_q & ~clr_stat);
        new_f_d   = rise_new   | (new_f_q   & ~clr_key);
        ovf_f_d   = (rise_new & new_f_q & ~clr_key) | (ovf_f_q & ~clr_key);
        int_d     = rise_irq   | (int_q     & ~interrupt_ack);
    end

    always_comb begin
        rd_mux = '0;
        if (rd_off == ADDR_W'(0)) begin
            rd_mux[3:0] = {ovf_f_q, new_f_q, ready_f_q, irq_f_q};
        end
        if (rd_off == ADDR_W'(1)) begin
            rd_mux = key_q;
        end
        for (int i = 0; i < N_DATA; i++) begin
            if (rd_off == ADDR_W'(i + 2)) begin
                rd_mux = data_q[i];
            end
        end
    end

    // History resets high so a level already asserted at reset is not an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_hist_q   <= 1'b1;
            ready_hist_q <= 1'b1;
            new_hist_q   <= 1'b1;
            for (int i = 0; i < N_DATA; i++) begin
                data_q[i] <= '0;
            end
            key_q     <= '0;
            in_port_q <= '0;
            irq_f_q   <= 1'b0;
            ready_f_q <= 1'b0;
            new_f_q   <= 1'b0;
            ovf_f_q   <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            irq_hist_q   <= irq;
            ready_hist_q <= ready;
            new_hist_q   <= new_data;
            for (int i = 0; i < N_DATA; i++) begin
                data_q[i] <= data_d[i];
            end
            key_q     <= key_d;
            in_port_q <= rd_mux;
            irq_f_q   <= irq_f_d;
            ready_f_q <= ready_f_d;
            new_f_q   <= new_f_d;
            ovf_f_q   <= ovf_f_d;
            int_q     <= int_d;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = int_q;

endmodule

// File: tb/tb_banco_reg_entrada_param.sv
// Testbench for banco_reg_entrada_param: directed scenarios then random traffic,
// all checked against an event-level reference model of the register bank.
module tb_banco_reg_entrada_param;

    localparam int         N    = 11;
    localparam logic [7:0] BASE = 8'h10;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   entrada;
    logic [N-1:0] wr_en;
    logic         irq, ready, new_data;
    logic [7:0]   data_teclado;
    logic [7:0]   port_id;
    logic         read_strobe;
    logic [7:0]   in_port;
    logic         interrupt;
    logic         interrupt_ack;

    int assertions = 0;
    int failures   = 0;

    // Reference model state
    logic [7:0] mData [N];
    logic [7:0] mKey;
    bit         mIrqF, mReadyF, mNewF, mOvfF, mInt;
    bit         pIrq, pReady, pNew;
    logic [7:0] expIn;

    banco_reg_entrada_param #(
        .DATA_W(8), .N_DATA(N), .ADDR_W(8), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .entrada(entrada), .wr_en(wr_en),
        .irq(irq), .ready(ready), .new_data(new_data),
        .data_teclado(data_teclado), .port_id(port_id),
        .read_strobe(read_strobe), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    function automatic int offsetOf(input logic [7:0] p);
        return (int'(p) - int'(BASE) + 256) % 256;
    endfunction

    function automatic logic [7:0] readModel(input logic [7:0] p);
        int off;
        off = offsetOf(p);
        if (off == 0) return {4'h0, mOvfF, mNewF, mReadyF, mIrqF};
        if (off == 1) return mKey;
        if (off >= 2 && off < 2 + N) return mData[off - 2];
        return 8'h00;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) mData[i] = 8'h00;
        mKey = 8'h00;
        {mIrqF, mReadyF, mNewF, mOvfF, mInt} = '0;
        {pIrq, pReady, pNew} = 3'b111;
        expIn = 8'h00;
    endtask

    task automatic checkOutput(input string tag);
        assertions++;
        assert (in_port === expIn) else begin
            failures++;
            $error("FAIL %s in_port got %h expected %h", tag, in_port, expIn);
        end
        assertions++;
        assert (interrupt === mInt) else begin
            failures++;
            $error("FAIL %s interrupt got %b expected %b", tag, interrupt, mInt);
        end
    endtask

    // One clock: the model applies the event rules to the inputs seen at the edge.
    task automatic applyStimulus(input string tag);
        bit riseI, riseR, riseN, clrS, clrK, hadNew;
        logic [7:0] nextIn;
        nextIn = readModel(port_id);
        riseI  = irq && !pIrq;
        riseR  = ready && !pReady;
        riseN  = new_data && !pNew;
        clrS   = read_strobe && offsetOf(port_id) == 0;
        clrK   = read_strobe && offsetOf(port_id) == 1;
        hadNew = mNewF;
        @(posedge clk);
        if (clrS) begin mIrqF = 0; mReadyF = 0; end
        if (clrK) begin mNewF = 0; mOvfF = 0; end
        if (riseI) mIrqF = 1;
        if (riseR) mReadyF = 1;
        if (riseN) begin
            mKey = data_teclado;
            if (hadNew && !clrK) mOvfF = 1;
            mNewF = 1;
        end
        if (interrupt_ack) mInt = 0;
        if (riseI) mInt = 1;
        for (int i = 0; i < N; i++) if (wr_en[i]) mData[i] = entrada;
        pIrq = irq; pReady = ready; pNew = new_data;
        expIn = nextIn;
        #1;
        checkOutput(tag);
    endtask

    task automatic quiet();
        wr_en = '0; irq = 0; ready = 0; new_data = 0;
        read_strobe = 0; interrupt_ack = 0;
    endtask

    task automatic doReset(input string tag);
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_async"});
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; entrada = 8'h00; wr_en = '0; data_teclado = 8'h00;
        irq = 1; ready = 1; new_data = 1; read_strobe = 0; interrupt_ack = 0;
        port_id = BASE;
        modelReset();
        @(negedge clk);
        doReset("reset_inputs_high");

        for (int k = 0; k < 5; k++) applyStimulus("hold_high_status");
        for (int a = 1; a < 2 + N; a++) begin
            port_id = BASE + 8'(a);
            applyStimulus("post_reset_regs");
        end
        applyStimulus("post_reset_last");
        quiet();
        applyStimulus("inputs_low");

        wr_en = N'(1) << 3; entrada = 8'h5A;
        applyStimulus("load_reg3");
        wr_en = '0; entrada = 8'hFF;
        port_id = BASE + 8'd5;
        applyStimulus("read_reg3_latency");
        applyStimulus("read_reg3");
        for (int a = 0; a < 2 + N; a++) begin
            port_id = BASE + 8'(a);
            applyStimulus("scan_after_load");
        end
        applyStimulus("scan_last");

        port_id = BASE;
        new_data = 1; data_teclado = 8'h31; applyStimulus("key_first");
        new_data = 0; data_teclado = 8'h00; applyStimulus("key_gap");
        new_data = 1; data_teclado = 8'h32; applyStimulus("key_second");
        new_data = 0; applyStimulus("status_ovf_latency");
        applyStimulus("status_0C");
        port_id = BASE + 8'd1; read_strobe = 1; applyStimulus("key_read_clear");
        read_strobe = 0; applyStimulus("key_value_32");
        port_id = BASE; applyStimulus("status_after_key_lat");
        applyStimulus("status_00");

        irq = 1; applyStimulus("irq_rise");
        irq = 0; applyStimulus("status_01");
        interrupt_ack = 1; applyStimulus("ack");
        interrupt_ack = 0; applyStimulus("status_still_01");
        read_strobe = 1; applyStimulus("status_read_clear");
        read_strobe = 0; applyStimulus("status_cleared_lat");
        applyStimulus("status_cleared");

        irq = 1; interrupt_ack = 1; applyStimulus("irq_and_ack");
        irq = 0; interrupt_ack = 0; applyStimulus("irq_ack_after");

        read_strobe = 1; ready = 1; applyStimulus("clear_vs_ready");
        read_strobe = 0; ready = 0; applyStimulus("ready_kept_lat");
        applyStimulus("status_02");
        read_strobe = 1; applyStimulus("status_read_02");
        read_strobe = 0; applyStimulus("status_after_02");

        irq = 1; ready = 1; new_data = 1; data_teclado = 8'h77;
        applyStimulus("events_for_unmapped");
        quiet();
        port_id = BASE + 8'(2 + N); read_strobe = 1; applyStimulus("unmapped_high");
        port_id = BASE - 8'd1; applyStimulus("unmapped_below");
        read_strobe = 0; applyStimulus("unmapped_below_val");
        port_id = BASE; applyStimulus("flags_kept_lat");
        applyStimulus("flags_kept");

        for (int k = 0; k < 400; k++) begin
            entrada       = 8'($urandom);
            wr_en         = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            irq           = ($urandom_range(0, 3) == 0);
            ready         = ($urandom_range(0, 3) == 0);
            new_data      = ($urandom_range(0, 3) == 0);
            data_teclado  = 8'($urandom);
            port_id       = 8'(int'(BASE) + $urandom_range(0, N + 3) - 2);
            read_strobe   = ($urandom_range(0, 2) == 0);
            interrupt_ack = ($urandom_range(0, 5) == 0);
            applyStimulus("random");
            if (k == 200) begin
                #2;
                doReset("mid_reset");
                quiet();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
